io_byte_splitter: RTL and testbench
===================================

# io_byte_splitter

Upstream feeder for the 8-bit I/O register window. Accepts one CPU-side I/O access of 1–4 bytes with a 32-bit data bus and replays it as sequential single-byte Avalon-MM reads or writes at incrementing byte addresses. For reads it assembles the returned bytes little-endian into a 32-bit response. The byte-side port drives the 8-bit slave directly, which widens it onto the 32-bit register bus.

## Interface
Parameters:
- `ADDR_W`, default 3: byte-side address width; the window holds 2^ADDR_W bytes.
- `RD_LATENCY`, default 1, legal range 1–7: cycles from an `av_read` cycle to the cycle in which `av_readdata` is valid.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `req_valid`  in  1  — access request.
- `req_ready`  out  1  — high only in IDLE; the access is accepted on the edge where `req_valid && req_ready`.
- `req_write`  in  1  — 1 = write, 0 = read.
- `req_address`  in  ADDR_W  — first byte address.
- `req_length`  in  3  — byte count 0–7.
- `req_wdata`  in  32  — write data; byte k is bits [8k+7:8k].
- `rsp_done`  out  1  — one-cycle completion pulse.
- `rsp_rdata`  out  32  — assembled read data; valid while `rsp_done` is high and held until the next accept.
- `rsp_err`  out  1  — window-overrun flag; valid with `rsp_done`.
- `av_address`  out  ADDR_W  — byte-side address.
- `av_read`  out  1  — byte-side read strobe.
- `av_write`  out  1  — byte-side write strobe.
- `av_writedata`  out  8  — byte-side write data.
- `av_readdata`  in  8  — byte-side read data.

## Operation
- States: IDLE, WR, RD_ISSUE, RD_WAIT, DONE.
- On accept, the block latches write, address, length and wdata, and clears `rsp_rdata` to 0.
- Effective length N = min(`req_length`, 4).
- N = 0: go to DONE; no bus cycle is issued.
- Write (WR):
  - One `av_write` cycle per byte, back-to-back.
  - Byte k: `av_address` = `req_address` + k, `av_writedata` = wdata byte k.
  - After byte N-1, go to DONE.
- Read, RD_ISSUE: one `av_read` cycle for byte k, then go to RD_WAIT.
- Read, RD_WAIT:
  - Counts RD_LATENCY cycles. In the last of them, `av_readdata` is captured into lane k of `rsp_rdata`.
  - Then go to RD_ISSUE for byte k+1, or to DONE after byte N-1.
- DONE: `rsp_done` = 1 for one cycle, then go to IDLE.
- Lanes ≥ N of `rsp_rdata` read 0.
- Address arithmetic is modulo 2^ADDR_W; for example, 3'd7 + 1 wraps to 3'd0.
- `av_read` and `av_write` are never high together. Both are low in IDLE and DONE.
- `req_*` inputs are ignored outside IDLE.
- Reset, including mid-transfer: all outputs return to their reset values at once and the state returns to IDLE. No `rsp_done` is issued for the aborted access.

## Timing
- Reset values:
  - `req_ready` = 1 (IDLE).
  - All other outputs = 0.
- All outputs are registered; there is no combinational path from `req_*` to `av_*`.
- Accept edge = T0.
- Write: `av_write` is high in cycles T0+1 … T0+N. `rsp_done` is high at T0+N+1. `req_ready` returns high at T0+N+2.
- Read:
  - L = RD_LATENCY.
  - Byte k strobe at T0+1+k(L+1); its data is captured in cycle T0+1+k(L+1)+L.
  - `rsp_done` is high at T0+1+N(L+1).
- N = 0: `rsp_done` is high at T0+1.
- Throughput: one access in flight at a time.

## Configuration
- `IO_BYTE_SPLIT_GUARD_EN`
- Defined:
  - A byte whose address would wrap past 2^ADDR_W−1 is not issued: no strobe and no wait cycles.
  - For reads, its lane returns 8'hFF.
  - `rsp_err` = 1 with `rsp_done`.
  - The `rsp_done` time shrinks by the skipped byte slots.
- Undefined: addresses wrap modulo 2^ADDR_W and `rsp_err` is tied to 0.

## Structure
- Package `io_byte_split_pkg` holds:
  - the state enum;
  - `MAX_BYTES` = 4;
  - the lane width 8;
  - the 8'hFF fill constant.
- One sub-module, `io_byte_split_rdlat`: a loadable down-counter producing the capture strobe after RD_LATENCY cycles; it is reset by `rst_n`.

## Test plan
- Write: len 2, addr 3, wdata 32'h0000_BEEF, L = 1 → `av_write` at T0+1 (addr 3, data EF) and T0+2 (addr 4, data BE); `rsp_done` at T0+3.
- Read: len 4, addr 0, slave returns 11, 22, 33, 44, L = 2 → `rsp_rdata` = 32'h4433_2211; `rsp_done` at T0+13.
- Read: len 1 → `rsp_rdata` = 32'h0000_00xx with only lane 0 filled. Length 6 behaves exactly like length 4.
- Wrap: read len 2 at addr 7.
  - Without guard: addresses 7 then 0; `rsp_err` = 0.
  - With `IO_BYTE_SPLIT_GUARD_EN`: only addr 7 is read; lane 1 = FF; `rsp_err` = 1; `rsp_done` at T0+3 for L = 1.
- Len 0 → no strobes; `rsp_done` at T0+1; `rsp_rdata` = 0.
- `rst_n` low during the third byte of a write → `av_write` drops immediately; no `rsp_done`; `req_ready` = 1 after release.

Source files
------------

// File: rtl/io_byte_split_pkg.sv
// Shared types and constants for the I/O byte splitter.
// The optional window-overrun guard is enabled with IO_BYTE_SPLIT_GUARD_EN.
package io_byte_split_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned LANE_W    = 8;
  localparam logic [7:0]  FILL_BYTE = 8'hFF;

  function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] k);
    return word[{k, 3'b000} +: LANE_W];
  endfunction

  function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{k, 3'b000} +: LANE_W] = b;
    return r;
  endfunction

  // Lanes in [from, to) are set to the fill byte, all others are zero.
  function automatic logic [31:0] fill_lanes(input logic [2:0] from, input logic [2:0] to);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i >= 32'(from) && i < 32'(to)) r[i*LANE_W +: LANE_W] = FILL_BYTE;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_byte_split_rdlat.sv
// Read-latency down-counter: after load, fire is high in the LATENCY-th following cycle.
module io_byte_split_rdlat #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic fire
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= 3'(LATENCY);
    end else if (count != '0) begin
      count <= count - 3'd1;
    end
  end

  assign fire = (count == 3'd1);

endmodule

// File: rtl/io_byte_splitter.sv
// Splits one 1-4 byte CPU I/O access into sequential single-byte Avalon-MM cycles.
// Define IO_BYTE_SPLIT_GUARD_EN to suppress bytes that would wrap past the window end.
module io_byte_splitter
  import io_byte_split_pkg::*;
#(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [2:0]        req_length,
  input  logic [31:0]       req_wdata,
  output logic              rsp_done,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [7:0]        av_writedata,
  input  logic [7:0]        av_readdata
);

  state_t            state, state_nx;
  logic [2:0]        idx, idx_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [2:0]        len_q, len_nx;
  logic              err_q, err_nx;
  logic [31:0]       wdata_q, wdata_nx;

  logic              ready_nx, done_nx, rsp_err_nx, read_nx, write_nx;
  logic [31:0]       rdata_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [7:0]        wrdata_nx;

  logic [2:0]        req_n, req_m, idx_inc;
  logic              req_err;
  logic              lat_load, lat_fire;

  io_byte_split_rdlat #(.LATENCY(RD_LATENCY)) u_rdlat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lat_load),
    .fire  (lat_fire)
  );

  // Bytes actually issued (req_m) versus requested (req_n); they differ only when guarded.
  always_comb begin
    req_n = (req_length > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : req_length;
`ifdef IO_BYTE_SPLIT_GUARD_EN
    begin
      int unsigned space;
      space = (32'd1 << ADDR_W) - 32'(req_address);
      req_m = (32'(req_n) > space) ? 3'(space) : req_n;
    end
    req_err = (req_m != req_n);
`else
    req_m   = req_n;
    req_err = 1'b0;
`endif
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    cnt_nx     = cnt;
    len_nx     = len_q;
    err_nx     = err_q;
    wdata_nx   = wdata_q;
    ready_nx   = req_ready;
    done_nx    = 1'b0;
    rsp_err_nx = 1'b0;
    rdata_nx   = rsp_rdata;
    addr_nx    = av_address;
    read_nx    = 1'b0;
    write_nx   = 1'b0;
    wrdata_nx  = av_writedata;
    lat_load   = 1'b0;
    idx_inc    = idx + 3'd1;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          wdata_nx = req_wdata;
          len_nx   = req_n;
          cnt_nx   = req_m;
          err_nx   = req_err;
          idx_nx   = '0;
          rdata_nx = '0;
          addr_nx  = req_address;
          ready_nx = 1'b0;
          if (req_m == '0) begin
            state_nx   = ST_DONE;
            done_nx    = 1'b1;
            rsp_err_nx = req_err;
          end else if (req_write) begin
            state_nx  = ST_WR;
            write_nx  = 1'b1;
            wrdata_nx = req_wdata[7:0];
          end else begin
            state_nx = ST_RD_ISSUE;
            read_nx  = 1'b1;
          end
        end
      end

      ST_WR: begin
        if (idx_inc == cnt) begin
          state_nx   = ST_DONE;
          done_nx    = 1'b1;
          rsp_err_nx = err_q;
        end else begin
          idx_nx    = idx_inc;
          write_nx  = 1'b1;
          addr_nx   = av_address + ADDR_W'(1);
          wrdata_nx = lane_get(wdata_q, idx_inc[1:0]);
        end
      end

      ST_RD_ISSUE: begin
        state_nx = ST_RD_WAIT;
        lat_load = 1'b1;
      end

      ST_RD_WAIT: begin
        if (lat_fire) begin
          rdata_nx = lane_put(rsp_rdata, idx[1:0], av_readdata);
          if (idx_inc == cnt) begin
            // Skipped (guarded) lanes are filled on the way into DONE.
            rdata_nx   = rdata_nx | fill_lanes(cnt, len_q);
            state_nx   = ST_DONE;
            done_nx    = 1'b1;
            rsp_err_nx = err_q;
          end else begin
            idx_nx   = idx_inc;
            state_nx = ST_RD_ISSUE;
            read_nx  = 1'b1;
            addr_nx  = av_address + ADDR_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
        ready_nx = 1'b1;
      end

      default: begin
        state_nx = ST_IDLE;
        ready_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cnt          <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      req_ready    <= 1'b1;
      rsp_done     <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      av_address   <= '0;
      av_read      <= 1'b0;
      av_write     <= 1'b0;
      av_writedata <= '0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      cnt          <= cnt_nx;
      len_q        <= len_nx;
      err_q        <= err_nx;
      wdata_q      <= wdata_nx;
      req_ready    <= ready_nx;
      rsp_done     <= done_nx;
      rsp_rdata    <= rdata_nx;
      rsp_err      <= rsp_err_nx;
      av_address   <= addr_nx;
      av_read      <= read_nx;
      av_write     <= write_nx;
      av_writedata <= wrdata_nx;
    end
  end

endmodule

// File: tb/tb_io_byte_splitter.sv
// Self-checking bench for io_byte_splitter: cycle-schedule model plus directed and random accesses.
module tb_io_byte_splitter;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned WIN    = 1 << ADDR_W;
  localparam int          L      = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_address = '0;
  logic [2:0]        req_length = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_done;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [7:0]        av_writedata;
  logic [7:0]        av_readdata = '0;

  io_byte_splitter #(.ADDR_W(ADDR_W), .RD_LATENCY(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_length   (req_length),
    .req_wdata    (req_wdata),
    .rsp_done     (rsp_done),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .av_address   (av_address),
    .av_read      (av_read),
    .av_write     (av_write),
    .av_writedata (av_writedata),
    .av_readdata  (av_readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Byte-wide slave: writes land in slave_mem, read data appears L cycles after the strobe.
  logic [7:0] slave_mem [WIN];
  logic [7:0] model_mem [WIN];
  logic [7:0] hist [8];

  always @(negedge clk) begin
    if (av_write) slave_mem[av_address] = av_writedata;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = av_read ? slave_mem[av_address] : 8'($urandom);
    av_readdata = hist[L];
  end

  // Model: per accepted access, derive the bus schedule and response from the access rules.
  logic        m_busy = 1'b0;
  int          m_t0, m_done, m_n, m_m;
  logic        m_wr;
  int          m_a;
  logic [31:0] m_wd, m_exp_rd, m_held = '0;
  logic        m_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_held = '0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_outputs", {27'd0, rsp_done, rsp_err, av_read, av_write, 1'b0}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
    end else begin
      if (m_busy && cyc > m_done) m_busy = 1'b0;
      if (!m_busy) begin
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_strobes", {28'd0, av_read, av_write, rsp_done, rsp_err}, 32'd0);
        chk("idle_rdata", rsp_rdata, m_held);
        if (req_valid) begin
          m_busy = 1'b1;
          m_t0   = cyc;
          m_wr   = req_write;
          m_a    = int'(req_address);
          m_wd   = req_wdata;
          m_n    = (req_length > 3'd4) ? 4 : int'(req_length);
`ifdef IO_BYTE_SPLIT_GUARD_EN
          m_m    = (m_n > int'(WIN) - m_a) ? int'(WIN) - m_a : m_n;
`else
          m_m    = m_n;
`endif
          m_err  = (m_m != m_n);
          m_done = m_wr ? m_t0 + m_m + 1 : m_t0 + 1 + m_m * (L + 1);
          m_exp_rd = '0;
          if (!m_wr) begin
            for (int j = 0; j < 4; j++) begin
              if (j < m_m) m_exp_rd[8*j +: 8] = model_mem[(m_a + j) % int'(WIN)];
              else if (j < m_n) m_exp_rd[8*j +: 8] = 8'hFF;
            end
          end
        end
      end else begin
        int  o, k;
        logic ew, er;
        o  = cyc - m_t0 - 1;
        k  = m_wr ? o : o / (L + 1);
        ew = m_wr && o < m_m;
        er = !m_wr && (o % (L + 1) == 0) && k < m_m;
        chk("busy_ready", 32'(req_ready), 32'd0);
        chk("av_write", 32'(av_write), 32'(ew));
        chk("av_read", 32'(av_read), 32'(er));
        if (ew || er) chk("av_address", 32'(av_address), 32'((m_a + k) % int'(WIN)));
        if (ew) begin
          chk("av_writedata", 32'(av_writedata), 32'(m_wd[8*k +: 8]));
          model_mem[(m_a + k) % int'(WIN)] = m_wd[8*k +: 8];
        end
        chk("rsp_done", 32'(rsp_done), 32'(cyc == m_done));
        if (cyc == m_done) begin
          chk("rsp_rdata", rsp_rdata, m_exp_rd);
          chk("rsp_err", 32'(rsp_err), 32'(m_err));
          m_held = m_exp_rd;
        end
      end
    end
  end

  task automatic preload(input int a, input logic [7:0] b);
    slave_mem[a] = b;
    model_mem[a] = b;
  endtask

  // Issue one access from an idle DUT and return its latency from the accept edge.
  task automatic access(input logic w, input int a, input int len, input logic [31:0] wd,
                        input logic noise, output int lat, output logic [31:0] rd,
                        output logic er);
    int t0, k;
    chk("access_start_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_address = ADDR_W'(a);
    req_length = 3'(len); req_wdata = wd;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!rsp_done && k < 100) begin
      if (noise) begin
        req_valid = 1'($urandom); req_write = 1'($urandom);
        req_address = ADDR_W'($urandom); req_length = 3'($urandom); req_wdata = $urandom;
      end
      @(posedge clk); #1;
      k++;
    end
    req_valid = 1'b0;
    if (k >= 100) begin
      failures++;
      $display("FAIL access_timeout actual=no_done required=done_within_100");
    end
    lat = cyc - t0;
    rd  = rsp_rdata;
    er  = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, dcount, t0;
    logic [31:0] rd;
    logic er;
    logic [7:0] keep5;

    for (int i = 0; i < 8; i++) hist[i] = 8'h00;
    for (int i = 0; i < int'(WIN); i++) preload(i, 8'($urandom));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_lit", 32'(req_ready), 32'd1);
    chk("reset_rdata_lit", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write len 2 @3, data BEEF.
    keep5 = slave_mem[5];
    access(1'b1, 3, 2, 32'h0000_BEEF, 1'b0, lat, rd, er);
    chk("wr2_latency", 32'(lat), 32'd3);
    chk("wr2_byte3", 32'(slave_mem[3]), 32'h EF);
    chk("wr2_byte4", 32'(slave_mem[4]), 32'h BE);
    chk("wr2_byte5_untouched", 32'(slave_mem[5]), 32'(keep5));

    preload(0, 8'h11); preload(1, 8'h22); preload(2, 8'h33); preload(3, 8'h44);
    access(1'b0, 0, 4, 32'h0, 1'b0, lat, rd, er);
    chk("rd4_data", rd, 32'h4433_2211);
    chk("rd4_latency", 32'(lat), 32'd13);

    access(1'b0, 0, 1, 32'h0, 1'b0, lat, rd, er);
    chk("rd1_data", rd, 32'h0000_0011);
    chk("rd1_latency", 32'(lat), 32'd4);

    access(1'b0, 0, 6, 32'h0, 1'b0, lat, rd, er);
    chk("rd6_data", rd, 32'h4433_2211);
    chk("rd6_latency", 32'(lat), 32'd13);

    preload(7, 8'h77);
    access(1'b0, 7, 2, 32'h0, 1'b0, lat, rd, er);
`ifdef IO_BYTE_SPLIT_GUARD_EN
    chk("wrap_data", rd, 32'h0000_FF77);
    chk("wrap_err", 32'(er), 32'd1);
    chk("wrap_latency", 32'(lat), 32'd4);
`else
    chk("wrap_data", rd, 32'h0000_1177);
    chk("wrap_err", 32'(er), 32'd0);
    chk("wrap_latency", 32'(lat), 32'd7);
`endif

    access(1'b0, 5, 0, 32'h0, 1'b0, lat, rd, er);
    chk("len0_latency", 32'(lat), 32'd1);
    chk("len0_data", rd, 32'd0);

    // Reset in the middle of the third byte of a 4-byte write.
    req_valid = 1'b1; req_write = 1'b1; req_address = 3'd1;
    req_length = 3'd4; req_wdata = 32'hA1B2_C3D4;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_mid_pre_write", 32'(av_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_av_write", 32'(av_write), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dcount = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_done) dcount++;
    end
    chk("rst_mid_no_done", 32'(dcount), 32'd0);
    chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
    chk("rst_mid_byte3_unwritten", 32'(slave_mem[3] == 8'hB2), 32'd0);

    // Random accesses with ignored request noise while busy.
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      access(1'($urandom), int'($urandom_range(0, WIN - 1)), int'($urandom_range(0, 7)),
             $urandom, 1'b1, lat, rd, er);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
